// File: rtl/ebpf_pkg.sv
// Shared eBPF definitions: opcodes, instruction field positions,
// fetch state encoding, fault codes and the unpacked-field bundle.
package ebpf_pkg;

    localparam int MAX_PGM_WORDS = 4096;
    localparam int PC_W          = 12;
    localparam int MAX_REGS      = 11;

    localparam logic [7:0] OP_LDDW = 8'h18;
    localparam logic [7:0] OP_EXIT = 8'h95;

    localparam int OPC_LSB = 56;
    localparam int SRC_LSB = 52;
    localparam int DST_LSB = 48;
    localparam int OFF_LSB = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_REQ_HI,
        S_RESP_HI,
        S_OUT,
        S_FAULT
    } fetch_state_e;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_PC   = 2'd1;
    localparam logic [1:0] FC_REG  = 2'd2;
    localparam logic [1:0] FC_LDDW = 2'd3;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] off;
        logic [63:0] imm;
    } inst_fields_t;

    function automatic logic bad_reg(input logic [3:0] r);
        return r >= 4'(MAX_REGS);
    endfunction

endpackage

// File: rtl/ebpf_fetch_if.sv
// Fetch-stage bus bundle: control, program memory port, decode handshake.
// master = fetch stage, slave = surrounding CPU / memory.
interface ebpf_fetch_if;
    import ebpf_pkg::*;

    logic            start;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            mem_en;
    logic [PC_W-1:0] mem_addr;
    logic [63:0]     mem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [7:0]      inst_opcode;
    logic [3:0]      inst_src;
    logic [3:0]      inst_dst;
    logic [15:0]     inst_off;
    logic [63:0]     inst_imm;
    logic [PC_W-1:0] inst_pc;
    logic            inst_wide;
    logic            done;
    logic            fault;
    logic [1:0]      fault_code;

    modport master (
        input  start, redirect_valid, redirect_pc, mem_rdata, inst_ready,
        output mem_en, mem_addr, inst_valid, inst_opcode, inst_src,
        output inst_dst, inst_off, inst_imm, inst_pc, inst_wide,
        output done, fault, fault_code
    );

    modport slave (
        output start, redirect_valid, redirect_pc, mem_rdata, inst_ready,
        input  mem_en, mem_addr, inst_valid, inst_opcode, inst_src,
        input  inst_dst, inst_off, inst_imm, inst_pc, inst_wide,
        input  done, fault, fault_code
    );

endinterface

// File: rtl/ebpf_inst_unpack.sv
// Combinational slicer: 64-bit eBPF word -> opcode/src/dst/off fields
// plus the 32-bit immediate sign-extended to 64. Ports: word in, f out.
module ebpf_inst_unpack
    import ebpf_pkg::*;
(
    input  logic [63:0]  word,
    output inst_fields_t f
);

    always_comb begin
        f.opcode = word[OPC_LSB +: 8];
        f.src    = word[SRC_LSB +: 4];
        f.dst    = word[DST_LSB +: 4];
        f.off    = word[OFF_LSB +: 16];
        f.imm    = {{32{word[31]}}, word[31:0]};
    end

endmodule

// File: rtl/ebpf_fetch.sv
// eBPF fetch / pre-decode stage: reads program words, merges LDDW,
// hands one instruction at a time to decode. Ports: clk, rst, bus.
module ebpf_fetch
    import ebpf_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ebpf_fetch_if.master bus
);

    // pc carries one extra bit so running off the end faults, never wraps
    localparam logic [PC_W:0] PC_LIMIT = (PC_W+1)'(MAX_PGM_WORDS);
    localparam logic [PC_W:0] PC_ONE   = (PC_W+1)'(1);
    localparam logic [PC_W:0] PC_TWO   = (PC_W+1)'(2);

    fetch_state_e  state, state_d;
    logic [PC_W:0] pc, pc_d, pc_hi;
    inst_fields_t  f_rd, f_q;
    logic          wide_q;
    logic          done_q, done_d;
    logic          fault_q;
    logic [1:0]    code_q, code_d;
    logic          ld_lo, ld_hi;
    logic          hi_bad;

    ebpf_inst_unpack u_unpack (
        .word (bus.mem_rdata),
        .f    (f_rd)
    );

    assign pc_hi  = pc + PC_ONE;
    // LDDW second word: opcode, src, dst and offset must all be zero
    assign hi_bad = |bus.mem_rdata[63:32];

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        code_d       = code_q;
        done_d       = 1'b0;
        ld_lo        = 1'b0;
        ld_hi        = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_addr = pc[PC_W-1:0];
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pc >= PC_LIMIT) begin
                    code_d  = FC_PC;
                    state_d = S_FAULT;
                end else begin
                    bus.mem_en = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                ld_lo = 1'b1;
                if (bad_reg(f_rd.dst) || bad_reg(f_rd.src)) begin
                    code_d  = FC_REG;
                    state_d = S_FAULT;
                end else if (f_rd.opcode == OP_LDDW) begin
                    state_d = S_REQ_HI;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_REQ_HI: begin
                if (pc_hi >= PC_LIMIT) begin
                    code_d  = FC_PC;
                    state_d = S_FAULT;
                end else begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = pc_hi[PC_W-1:0];
                    state_d      = S_RESP_HI;
                end
            end
            S_RESP_HI: begin
                if (hi_bad) begin
                    code_d  = FC_LDDW;
                    state_d = S_FAULT;
                end else begin
                    ld_hi   = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.inst_ready) begin
                    if (f_q.opcode == OP_EXIT) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pc_d    = pc + (wide_q ? PC_TWO : PC_ONE);
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: begin
            end
            default: state_d = S_IDLE;
        endcase
        // redirect wins; a response still in flight is simply never used
        if (bus.redirect_valid && state != S_IDLE && state != S_FAULT) begin
            pc_d    = {1'b0, bus.redirect_pc};
            state_d = S_REQ;
            code_d  = code_q;
            done_d  = 1'b0;
            ld_lo   = 1'b0;
            ld_hi   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            f_q     <= '0;
            wide_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            done_q  <= done_d;
            fault_q <= (state_d == S_FAULT);
            code_q  <= code_d;
            if (ld_lo) begin
                f_q    <= f_rd;
                wide_q <= (f_rd.opcode == OP_LDDW);
            end
            if (ld_hi) begin
                f_q.imm <= {bus.mem_rdata[31:0], f_q.imm[31:0]};
            end
        end
    end

    assign bus.inst_valid  = (state == S_OUT);
    assign bus.inst_opcode = f_q.opcode;
    assign bus.inst_src    = f_q.src;
    assign bus.inst_dst    = f_q.dst;
    assign bus.inst_off    = f_q.off;
    assign bus.inst_imm    = f_q.imm;
    assign bus.inst_pc     = pc[PC_W-1:0];
    assign bus.inst_wide   = wide_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;

endmodule

// File: tb/tb_ebpf_fetch.sv
// Scoreboard bench for ebpf_fetch: a program-walking reference model
// queues expected instructions/done/fault; a monitor pops and compares.
module tb_ebpf_fetch;

    logic clk;
    logic rst;

    ebpf_fetch_if bus ();

    ebpf_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        int          kind;
        logic [7:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] off;
        logic [63:0] imm;
        logic [11:0] pc;
        logic        wide;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mkw(input logic [7:0] op,
        input logic [3:0] s, input logic [3:0] d,
        input logic [15:0] off, input logic [31:0] imm);
        return {op, s, d, off, imm};
    endfunction

    function automatic logic [7:0] rop();
        logic [7:0] o;
        do o = 8'($urandom()); while (o == 8'h18 || o == 8'h95);
        return o;
    endfunction

    function automatic logic [3:0] rreg();
        return 4'($urandom_range(0, 10));
    endfunction

    task automatic clr_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    // random straight-line program, LDDWs sprinkled in, EXIT at the end
    task automatic gen_prog(input int len);
        int i;
        i = 0;
        while (i < len) begin
            if ($urandom_range(0, 4) == 0 && i + 1 < len) begin
                mem[i]   = mkw(8'h18, rreg(), rreg(), 16'($urandom()),
                               32'($urandom()));
                mem[i+1] = {32'h0, 32'($urandom())};
                i += 2;
            end else begin
                mem[i] = mkw(rop(), rreg(), rreg(), 16'($urandom()),
                             32'($urandom()));
                i++;
            end
        end
        mem[i] = mkw(8'h95, 4'd0, 4'd0, 16'd0, 32'd0);
    endtask

    // reference model: walk memory from a PC, applying the fetch rules
    task automatic push_stream(input int unsigned start_pc);
        int unsigned p;
        logic [63:0] w, w2;
        exp_t e;
        p = start_pc;
        for (int n = 0; n < 5000; n++) begin
            e = '{default: 0};
            if (p >= 4096) begin
                e.kind = 2; e.code = 2'd1; sb.push_back(e); return;
            end
            w     = mem[p];
            e.op  = w[63:56];
            e.src = w[55:52];
            e.dst = w[51:48];
            e.off = w[47:32];
            e.pc  = 12'(p);
            if (e.src > 4'd10 || e.dst > 4'd10) begin
                e.kind = 2; e.code = 2'd2; sb.push_back(e); return;
            end
            if (e.op == 8'h18) begin
                if (p + 1 >= 4096) begin
                    e.kind = 2; e.code = 2'd1; sb.push_back(e); return;
                end
                w2 = mem[p+1];
                if (w2[63:32] != 32'd0) begin
                    e.kind = 2; e.code = 2'd3; sb.push_back(e); return;
                end
                e.imm  = {w2[31:0], w[31:0]};
                e.wide = 1'b1;
            end else begin
                e.imm = 64'(longint'(int'(w[31:0])));
            end
            sb.push_back(e);
            if (e.op == 8'h95) begin
                e = '{default: 0}; e.kind = 1; sb.push_back(e); return;
            end
            p += e.wide ? 2 : 1;
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok, input string nm);
        ok = 1'b0;
        e  = '{default: 0};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got event want none", nm);
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    // monitor
    initial begin
        logic pv, ph, pf;
        logic [127:0] pfld, cur;
        exp_t e;
        bit ok;
        pv = 0; ph = 0; pf = 0; pfld = '0;
        forever begin
            @(negedge clk);
            cur = {bus.inst_opcode, bus.inst_src, bus.inst_dst,
                   bus.inst_off, bus.inst_imm, bus.inst_pc, bus.inst_wide};
            if (rst) begin
                pv = 0; ph = 0; pf = 0;
            end else begin
                if (ph) chk("valid_after_hs", bus.inst_valid, 0);
                if (pv && !ph && bus.inst_valid) chk("hold_stable", cur, pfld);
                if (bus.inst_valid) chk("fetch_in_out", bus.mem_en, 0);
                ph = bus.inst_valid && bus.inst_ready;
                if (ph) begin
                    pop_exp(e, ok, "unexpected_inst");
                    if (ok) begin
                        chk("kind_inst", 0, e.kind);
                        chk("opcode", bus.inst_opcode, e.op);
                        chk("src", bus.inst_src, e.src);
                        chk("dst", bus.inst_dst, e.dst);
                        chk("off", bus.inst_off, e.off);
                        chk("imm", bus.inst_imm, e.imm);
                        chk("inst_pc", bus.inst_pc, e.pc);
                        chk("wide", bus.inst_wide, e.wide);
                    end
                end
                if (bus.done) begin
                    pop_exp(e, ok, "unexpected_done");
                    if (ok) chk("kind_done", 1, e.kind);
                end
                if (bus.fault && !pf) begin
                    pop_exp(e, ok, "unexpected_fault");
                    if (ok) begin
                        chk("kind_fault", 2, e.kind);
                        chk("fault_code", bus.fault_code, e.code);
                    end
                end
                pv   = bus.inst_valid;
                pf   = bus.fault;
                pfld = cur;
            end
        end
    end

    task automatic do_reset();
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        sb.delete();
        #2 rst = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
    endtask

    task automatic latency(input int want, input string nm);
        int n;
        n = 1;
        while (!bus.inst_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk(nm, n, want);
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2 bus.inst_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout got %0d left want 0", sb.size());
            sb.delete();
        end
        repeat (6) begin
            @(posedge clk);
            #2 bus.inst_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // start, then redirect while the first word is in RESP
    task automatic redirect_start(input logic [11:0] t);
        start_pulse();
        @(posedge clk);
        #2 bus.redirect_valid = 1'b1;
        bus.redirect_pc = t;
        @(posedge clk);
        #1 chk("redir_addr", {bus.mem_en, bus.mem_addr}, {1'b1, t});
        #1 bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit quiet;
        bus.mem_rdata = '0;
        clr_mem();
        do_reset();
        @(posedge clk);
        #1;
        chk("rst_ctl", {bus.inst_valid, bus.mem_en, bus.done,
                        bus.fault, bus.fault_code}, 0);
        chk("rst_fields", {bus.inst_imm, bus.inst_pc, bus.inst_wide}, 0);

        // mov r1,-1 ; LDDW ; EXIT at word 3
        mem[0] = 64'hB701_0000_FFFF_FFFF;
        mem[1] = 64'h1801_0000_89AB_CDEF;
        mem[2] = 64'h0000_0000_0123_4567;
        mem[3] = mkw(8'h95, 4'd0, 4'd0, 16'd0, 32'd0);
        push_stream(0);
        start_pulse();
        latency(3, "lat_normal");
        run(200);
        chk("idle_after_exit", {bus.inst_valid, bus.mem_en}, 0);

        // LDDW first, next instruction at pc 2
        do_reset(); clr_mem();
        mem[0] = 64'h1801_0000_89AB_CDEF;
        mem[1] = 64'h0000_0000_0123_4567;
        mem[2] = mkw(8'hB7, 4'd0, 4'd2, 16'd0, 32'h7);
        mem[3] = mkw(8'h95, 4'd0, 4'd0, 16'd0, 32'd0);
        push_stream(0);
        start_pulse();
        latency(5, "lat_lddw");
        run(200);

        // ready held low five cycles in OUT
        do_reset(); clr_mem();
        gen_prog(6);
        push_stream(0);
        start_pulse();
        latency(3, "lat_hold");
        repeat (5) @(posedge clk);
        #1 chk("valid_held", bus.inst_valid, 1);
        run(300);

        for (int k = 0; k < 5; k++) begin
            do_reset(); clr_mem();
            gen_prog($urandom_range(4, 20));
            push_stream(0);
            start_pulse();
            run(1000);
        end

        // redirects during RESP
        do_reset(); clr_mem();
        gen_prog(24);
        push_stream(16);
        redirect_start(12'h010);
        run(1000);

        do_reset(); clr_mem();
        gen_prog(40);
        begin
            int t;
            t = $urandom_range(1, 39);
            push_stream(t);
            redirect_start(12'(t));
        end
        run(1000);

        // bad dst: fault 2, then start/redirect ignored until rst
        do_reset(); clr_mem();
        mem[0] = mkw(8'hB7, 4'd0, 4'd11, 16'd0, 32'd1);
        push_stream(0);
        start_pulse();
        run(100);
        start_pulse();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 12'd5;
        quiet = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (bus.mem_en || bus.inst_valid) quiet = 1'b1;
        end
        bus.redirect_valid = 1'b0;
        chk("fault_quiet", quiet, 0);
        chk("fault_hold", {bus.fault, bus.fault_code}, 3'b110);
        do_reset();
        @(posedge clk);
        #1 chk("fault_clear", {bus.fault, bus.fault_code}, 0);

        // bad src after two good instructions
        clr_mem();
        gen_prog(6);
        mem[2] = mkw(8'h07, 4'd12, 4'd1, 16'd0, 32'd1);
        push_stream(0);
        start_pulse();
        run(300);

        // malformed LDDW second word
        do_reset(); clr_mem();
        mem[0] = 64'h1801_0000_89AB_CDEF;
        mem[1] = 64'h0100_0000_0123_4567;
        mem[2] = mkw(8'h95, 4'd0, 4'd0, 16'd0, 32'd0);
        push_stream(0);
        start_pulse();
        run(100);

        // LDDW at the last word: second word out of range
        do_reset(); clr_mem();
        mem[4095] = 64'h1801_0000_89AB_CDEF;
        push_stream(4095);
        redirect_start(12'hFFF);
        run(100);

        // ordinary instruction at the last word: pc steps past the end
        do_reset(); clr_mem();
        mem[4095] = mkw(8'hB7, 4'd0, 4'd3, 16'd0, 32'h8000_0000);
        push_stream(4095);
        redirect_start(12'hFFF);
        run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebpf_fetch.md
# ebpf_fetch

Instruction fetch and pre-decode stage feeding the eBPF CPU's decode state.
- Reads 64-bit instruction words from the synchronous program memory.
- Splits each word into opcode, dst, src, offset and immediate fields.
- Merges the two-word LDDW form into one 64-bit immediate.
- Presents one instruction at a time to the CPU over a valid/ready handshake.
- Accepts PC redirects from the branch/call logic.

## Interface
- MAX_PGM_WORDS, 4096, program memory depth in 64-bit words
- PC_W, 12, program counter width (log2 MAX_PGM_WORDS)
- MAX_REGS, 11, number of architectural registers; dst/src fields ≥ MAX_REGS fault
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins fetching at PC 0 from IDLE; ignored elsewhere
- redirect_valid  in  1  branch/call target valid
- redirect_pc  in  PC_W  new PC
- mem_en  out  1  program memory read enable
- mem_addr  out  PC_W  program memory word address
- mem_rdata  in  64  read data, valid the cycle after mem_en
- inst_valid  out  1  instruction fields valid
- inst_ready  in  1  decode accepts instruction
- inst_opcode  out  8  word bits [63:56]
- inst_src  out  4  bits [55:52]
- inst_dst  out  4  bits [51:48]
- inst_off  out  16  bits [47:32]
- inst_imm  out  64  sign-extended bits [31:0], or the LDDW 64-bit immediate
- inst_pc  out  PC_W  address of first word of instruction
- inst_wide  out  1  instruction is LDDW (occupies 2 words)
- done  out  1  one-cycle pulse after EXIT (0x95) handshake
- fault  out  1  sticky error flag
- fault_code  out  2  1 = PC out of range, 2 = bad register index, 3 = malformed LDDW

## Operation
- States: IDLE, REQ, RESP, REQ_HI, RESP_HI, OUT, FAULT.
- IDLE: on start, pc ← 0 and go to REQ.
- REQ: if pc ≥ MAX_PGM_WORDS, go to FAULT with code 1. Otherwise mem_en = 1, mem_addr = pc, go to RESP.
- RESP: register all fields from mem_rdata.
  - If dst ≥ MAX_REGS or src ≥ MAX_REGS, go to FAULT with code 2.
  - Else if opcode = 0x18, go to REQ_HI.
  - Else go to OUT.
- REQ_HI: if pc+1 ≥ MAX_PGM_WORDS, go to FAULT with code 1. Otherwise mem_en = 1, mem_addr = pc+1, go to RESP_HI.
- RESP_HI: the second word must have opcode, src, dst and offset all zero; otherwise go to FAULT with code 3. inst_imm ← {rdata[31:0], lo[31:0]}. Go to OUT.
- OUT: inst_valid = 1 and fields are held stable. On inst_ready:
  - pc ← pc + (inst_wide ? 2 : 1) and go to REQ.
  - If opcode = 0x95, pulse done and go to IDLE instead.
- Redirect: redirect_valid in any state other than IDLE or FAULT sets pc ← redirect_pc and goes to REQ.
  - Any in-flight read is discarded.
  - Redirect has priority over the normal transition.
  - If it coincides with an OUT handshake, the instruction counts as consumed, but the PC increment and done are suppressed.
- Non-wide immediates are sign-extended: inst_imm = {{32{w[31]}}, w[31:0]}.
- PC arithmetic is done in PC_W+1 bits so that overflow is detected rather than wrapped.
- FAULT: inst_valid = 0 and mem_en = 0; fault and fault_code are held until rst. start and redirect are ignored.

## Timing
- Reset values: state IDLE; pc 0; all outputs 0.
- Normal instruction: REQ in cycle n, inst_valid in cycle n+2. Throughput is at most one instruction per 3 cycles.
- LDDW: inst_valid in cycle n+4.
- inst_valid falls in the cycle after the handshake. It never drops without a handshake, except on redirect (falls next cycle) or rst.
- Redirect in cycle n: mem_addr = redirect_pc in cycle n+1.
- done is asserted in the cycle after the EXIT handshake, for one cycle.
- fault rises in the cycle after the offending REQ, RESP, REQ_HI or RESP_HI check.
- rst mid-operation returns to IDLE next cycle and discards any outstanding read.

## Structure
- Package ebpf_pkg holds:
  - OP_LDDW = 8'h18 and OP_EXIT = 8'h95;
  - field bit positions;
  - the fetch state enum and fault_code constants;
  - MAX_REGS.
- Sub-module ebpf_inst_unpack: combinational 64-bit word → fields slicer plus sign extension, also reused by the decode stage.

## Test plan
- Memory word 0 = 0xB7_01_0000_FFFFFFFF (mov r1, -1); start → inst_valid at cycle 2 with opcode 0xB7, dst 1, src 0, imm 0xFFFF_FFFF_FFFF_FFFF, inst_pc 0.
- LDDW: word 0 = 0x18_01_0000_89ABCDEF, word 1 = 0x0000_0000_01234567 → one instruction, imm 0x01234567_89ABCDEF, inst_wide 1; next instruction has inst_pc 2.
- Hold inst_ready low for 5 cycles in OUT → fields stable and no mem_en. Raise ready → next REQ at pc+1.
- Assert redirect_valid with redirect_pc 0x010 while in RESP → mem_addr 0x010 in the next cycle; stale word is never presented.
- Word with dst = 11 → fault = 1, fault_code 2, inst_valid never asserted. A later start is ignored until rst.
- EXIT at word 3 handshaken → done pulse for one cycle, state IDLE. PC 4095 holding an LDDW → fault_code 1.
